tcdm_branch_prio_ctrl: RTL and testbench

- Sequences the core-vs-HWPE priority of the heterogeneous TCDM interconnect.
- Watches per-cycle request/grant activity of the core (log) branch and the HWPE (shallow) branch.
- Drives the registered priority select the interconnect uses to resolve bank conflicts between the two branches.
- Provides fixed, starvation-protected and round-robin policies; sits next to the interconnect in the cluster interconnect wrapper.

---
 rtl/tcdm_branch_prio_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_tcdm_branch_prio_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_branch_prio_ctrl.sv
// tcdm_branch_prio_ctrl
// Registered core-vs-HWPE priority select for the heterogeneous TCDM
// interconnect. It watches request/grant activity of the core (log) branch
// and the HWPE (shallow) branch. It supports fixed priority, core priority
// with HWPE starvation protection (BOOST), and round-robin on contended cycles.
module tcdm_branch_prio_ctrl #(
    parameter int unsigned STALL_CNT_W = 8,
    parameter int unsigned BOOST_CNT_W = 4,
    parameter int unsigned EVT_CNT_W   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   en_i,
    input  logic [1:0]             policy_i,
    input  logic [STALL_CNT_W-1:0] max_stall_i,
    input  logic [BOOST_CNT_W-1:0] boost_len_i,
    input  logic [STALL_CNT_W-1:0] rr_period_i,
    input  logic                   core_req_i,
    input  logic                   core_gnt_i,
    input  logic                   hwpe_req_i,
    input  logic                   hwpe_gnt_i,
    output logic                   hwpe_prio_o,
    output logic                   boost_o,
    output logic                   boost_evt_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output logic [EVT_CNT_W-1:0]   boost_total_o
);

    typedef enum logic [1:0] {
        POL_CORE   = 2'b00,
        POL_HWPE   = 2'b01,
        POL_STARVE = 2'b10,
        POL_RR     = 2'b11
    } policy_e;

    typedef enum logic {
        ST_BASE  = 1'b0,
        ST_BOOST = 1'b1
    } state_e;

    localparam logic [STALL_CNT_W-1:0] STALL_ONE = STALL_CNT_W'(1);
    localparam logic [BOOST_CNT_W-1:0] BOOST_ONE = BOOST_CNT_W'(1);
    localparam logic [EVT_CNT_W-1:0]   EVT_ONE   = EVT_CNT_W'(1);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic [STALL_CNT_W-1:0] w_stall_cnt_nxt;
    logic [BOOST_CNT_W-1:0] r_boost_cnt;
    logic [BOOST_CNT_W-1:0] w_boost_cnt_nxt;
    logic                   r_hwpe_prio;
    logic                   w_hwpe_prio_nxt;
    logic                   r_boost_evt;
    logic                   w_boost_evt_nxt;
    logic [EVT_CNT_W-1:0]   r_boost_total;
    logic [EVT_CNT_W-1:0]   w_boost_total_nxt;
    logic [1:0]             r_policy_q;

    logic                   w_hwpe_stall;
    logic                   w_contended;
    logic                   w_policy_chg;
    logic [STALL_CNT_W-1:0] w_stall_inc;
    logic                   w_stall_hit;
    logic                   w_rr_hit;
    logic [BOOST_CNT_W-1:0] w_boost_load;
    logic [EVT_CNT_W-1:0]   w_total_inc;

    // The core grant carries no information any policy needs; it is kept on
    // the port list so the wrapper wiring stays uniform across both branches.
    logic                   w_unused;
    assign w_unused = core_gnt_i;

    assign w_hwpe_stall = hwpe_req_i & ~hwpe_gnt_i;
    assign w_contended  = core_req_i & hwpe_req_i;
    assign w_policy_chg = (policy_i != r_policy_q);

    // Stall/period counter saturates at all-ones instead of wrapping.
    assign w_stall_inc  = (r_stall_cnt == '1) ? r_stall_cnt : r_stall_cnt + STALL_ONE;
    assign w_stall_hit  = (max_stall_i != '0) && (r_stall_cnt == max_stall_i - STALL_ONE);
    assign w_rr_hit     = (rr_period_i != '0) && (r_stall_cnt == rr_period_i - STALL_ONE);

    // A zero boost length behaves as a single boost cycle.
    assign w_boost_load = (boost_len_i == '0) ? '0 : boost_len_i - BOOST_ONE;
    assign w_total_inc  = (r_boost_total == '1) ? r_boost_total : r_boost_total + EVT_ONE;

    // Next-state and next-output logic for all policies.
    always_comb begin
        w_state_nxt       = r_state;
        w_stall_cnt_nxt   = r_stall_cnt;
        w_boost_cnt_nxt   = r_boost_cnt;
        w_hwpe_prio_nxt   = r_hwpe_prio;
        w_boost_evt_nxt   = 1'b0;
        w_boost_total_nxt = r_boost_total;

        if (!en_i || w_policy_chg) begin
            w_state_nxt     = ST_BASE;
            w_stall_cnt_nxt = '0;
            w_boost_cnt_nxt = '0;
            w_hwpe_prio_nxt = (policy_i == POL_HWPE);
        end else begin
            case (policy_i)
                POL_CORE: begin
                    w_state_nxt     = ST_BASE;
                    w_stall_cnt_nxt = '0;
                    w_boost_cnt_nxt = '0;
                    w_hwpe_prio_nxt = 1'b0;
                end
                POL_HWPE: begin
                    w_state_nxt     = ST_BASE;
                    w_stall_cnt_nxt = '0;
                    w_boost_cnt_nxt = '0;
                    w_hwpe_prio_nxt = 1'b1;
                end
                POL_STARVE: begin
                    if (r_state == ST_BOOST) begin
                        // HWPE stalls are ignored while boosted.
                        w_stall_cnt_nxt = '0;
                        if (!hwpe_req_i || (r_boost_cnt == '0)) begin
                            w_state_nxt     = ST_BASE;
                            w_boost_cnt_nxt = '0;
                            w_hwpe_prio_nxt = 1'b0;
                        end else begin
                            w_boost_cnt_nxt = r_boost_cnt - BOOST_ONE;
                            w_hwpe_prio_nxt = 1'b1;
                        end
                    end else begin
                        w_hwpe_prio_nxt = 1'b0;
                        if (w_hwpe_stall && w_stall_hit) begin
                            w_state_nxt       = ST_BOOST;
                            w_stall_cnt_nxt   = '0;
                            w_boost_cnt_nxt   = w_boost_load;
                            w_hwpe_prio_nxt   = 1'b1;
                            w_boost_evt_nxt   = 1'b1;
                            w_boost_total_nxt = w_total_inc;
                        end else if (w_hwpe_stall) begin
                            w_stall_cnt_nxt = w_stall_inc;
                        end else begin
                            w_stall_cnt_nxt = '0;
                        end
                    end
                end
                POL_RR: begin
                    w_state_nxt     = ST_BASE;
                    w_boost_cnt_nxt = '0;
                    if (rr_period_i == '0) begin
                        w_stall_cnt_nxt = '0;
                        w_hwpe_prio_nxt = 1'b0;
                    end else if (w_contended) begin
                        if (w_rr_hit) begin
                            w_stall_cnt_nxt = '0;
                            w_hwpe_prio_nxt = ~r_hwpe_prio;
                        end else begin
                            w_stall_cnt_nxt = w_stall_inc;
                        end
                    end
                end
            endcase
        end
    end

    // State and output registers; clear acts as a synchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= ST_BASE;
            r_stall_cnt   <= '0;
            r_boost_cnt   <= '0;
            r_hwpe_prio   <= 1'b0;
            r_boost_evt   <= 1'b0;
            r_boost_total <= '0;
            r_policy_q    <= POL_CORE;
        end else if (clear_i) begin
            r_state       <= ST_BASE;
            r_stall_cnt   <= '0;
            r_boost_cnt   <= '0;
            r_hwpe_prio   <= 1'b0;
            r_boost_evt   <= 1'b0;
            r_boost_total <= '0;
            r_policy_q    <= POL_CORE;
        end else begin
            r_state       <= w_state_nxt;
            r_stall_cnt   <= w_stall_cnt_nxt;
            r_boost_cnt   <= w_boost_cnt_nxt;
            r_hwpe_prio   <= w_hwpe_prio_nxt;
            r_boost_evt   <= w_boost_evt_nxt;
            r_boost_total <= w_boost_total_nxt;
            r_policy_q    <= policy_i;
        end
    end

    assign hwpe_prio_o   = r_hwpe_prio;
    assign boost_o       = (r_state == ST_BOOST);
    assign boost_evt_o   = r_boost_evt;
    assign stall_cnt_o   = r_stall_cnt;
    assign boost_total_o = r_boost_total;

endmodule

// File: tb/tb_tcdm_branch_prio_ctrl.sv
// Self-checking bench for tcdm_branch_prio_ctrl: directed scenarios plus a
// randomized run, all compared cycle by cycle against a behavioural model.
module tb_tcdm_branch_prio_ctrl;

    localparam int STALL_MAX = 255;
    localparam int TOT_MAX   = 15;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       clear_i;
    logic       en_i;
    logic [1:0] policy_i;
    logic [7:0] max_stall_i;
    logic [3:0] boost_len_i;
    logic [7:0] rr_period_i;
    logic       core_req_i;
    logic       core_gnt_i;
    logic       hwpe_req_i;
    logic       hwpe_gnt_i;
    logic       hwpe_prio_o;
    logic       boost_o;
    logic       boost_evt_o;
    logic [7:0] stall_cnt_o;
    logic [3:0] boost_total_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_prev_pol;
    int m_stall;
    int m_left;
    int m_total;
    bit m_boost;
    bit m_prio;
    bit m_evt;

    tcdm_branch_prio_ctrl #(
        .STALL_CNT_W (8),
        .BOOST_CNT_W (4),
        .EVT_CNT_W   (4)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear_i       (clear_i),
        .en_i          (en_i),
        .policy_i      (policy_i),
        .max_stall_i   (max_stall_i),
        .boost_len_i   (boost_len_i),
        .rr_period_i   (rr_period_i),
        .core_req_i    (core_req_i),
        .core_gnt_i    (core_gnt_i),
        .hwpe_req_i    (hwpe_req_i),
        .hwpe_gnt_i    (hwpe_gnt_i),
        .hwpe_prio_o   (hwpe_prio_o),
        .boost_o       (boost_o),
        .boost_evt_o   (boost_evt_o),
        .stall_cnt_o   (stall_cnt_o),
        .boost_total_o (boost_total_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev_pol = 0;
        m_stall    = 0;
        m_left     = 0;
        m_total    = 0;
        m_boost    = 1'b0;
        m_prio     = 1'b0;
        m_evt      = 1'b0;
    endtask

    // One clock edge of the priority rules, using the inputs currently applied.
    task automatic model_step();
        bit stall;
        bit cont;
        int pol;
        stall = hwpe_req_i & ~hwpe_gnt_i;
        cont  = core_req_i & hwpe_req_i;
        pol   = int'(policy_i);
        if (clear_i) begin
            model_reset();
            return;
        end
        m_evt = 1'b0;
        if (!en_i || pol != m_prev_pol) begin
            m_boost = 1'b0;
            m_stall = 0;
            m_left  = 0;
            m_prio  = (pol == 1);
        end else if (pol == 0 || pol == 1) begin
            m_boost = 1'b0;
            m_stall = 0;
            m_prio  = (pol == 1);
        end else if (pol == 2) begin
            if (m_boost) begin
                m_stall = 0;
                if (!hwpe_req_i) begin
                    m_boost = 1'b0;
                end else begin
                    m_left = m_left - 1;
                    if (m_left <= 0) m_boost = 1'b0;
                end
            end else if (stall && max_stall_i != 0 && m_stall + 1 == int'(max_stall_i)) begin
                m_boost = 1'b1;
                m_evt   = 1'b1;
                m_stall = 0;
                m_left  = (boost_len_i == 0) ? 1 : int'(boost_len_i);
                m_total = (m_total < TOT_MAX) ? m_total + 1 : TOT_MAX;
            end else if (stall) begin
                m_stall = (m_stall < STALL_MAX) ? m_stall + 1 : STALL_MAX;
            end else begin
                m_stall = 0;
            end
            m_prio = m_boost;
        end else begin
            m_boost = 1'b0;
            if (rr_period_i == 0) begin
                m_prio  = 1'b0;
                m_stall = 0;
            end else if (cont) begin
                if (m_stall + 1 == int'(rr_period_i)) begin
                    m_prio  = ~m_prio;
                    m_stall = 0;
                end else begin
                    m_stall = (m_stall < STALL_MAX) ? m_stall + 1 : STALL_MAX;
                end
            end
        end
        m_prev_pol = pol;
    endtask

    task automatic check_all();
        check_eq("prio",  32'(hwpe_prio_o),   32'(m_prio));
        check_eq("boost", 32'(boost_o),       32'(m_boost));
        check_eq("evt",   32'(boost_evt_o),   32'(m_evt));
        check_eq("stall", 32'(stall_cnt_o),   32'(m_stall));
        check_eq("total", 32'(boost_total_o), 32'(m_total));
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_req(input bit creq, input bit cgnt, input bit hreq, input bit hgnt);
        core_req_i = creq;
        core_gnt_i = cgnt;
        hwpe_req_i = hreq;
        hwpe_gnt_i = hgnt;
    endtask

    task automatic pulse_reset();
        #2 rst_i = 1'b1;
        #1;
        check_eq("rst_prio",  32'(hwpe_prio_o),   32'd0);
        check_eq("rst_boost", 32'(boost_o),       32'd0);
        check_eq("rst_evt",   32'(boost_evt_o),   32'd0);
        check_eq("rst_stall", 32'(stall_cnt_o),   32'd0);
        check_eq("rst_total", 32'(boost_total_o), 32'd0);
        model_reset();
        #1 rst_i = 1'b0;
    endtask

    initial begin : stim
        bit prev_evt;
        bit rr_exp [8];
        rr_exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        rst_i       = 1'b1;
        clear_i     = 1'b0;
        en_i        = 1'b1;
        policy_i    = 2'b00;
        max_stall_i = 8'd4;
        boost_len_i = 4'd3;
        rr_period_i = 8'd2;
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        check_eq("init_prio",  32'(hwpe_prio_o),   32'd0);
        check_eq("init_boost", 32'(boost_o),       32'd0);
        check_eq("init_stall", 32'(stall_cnt_o),   32'd0);
        check_eq("init_total", 32'(boost_total_o), 32'd0);
        model_reset();
        rst_i = 1'b0;

        // Continuous HWPE stall: boost of 3 cycles every 7 cycles.
        policy_i = 2'b10;
        tick();
        set_req(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 25; k++) begin
            tick();
            check_eq("t1_prio",  32'(hwpe_prio_o), 32'(((k % 7) >= 3 && (k % 7) <= 5) ? 1 : 0));
            check_eq("t1_evt",   32'(boost_evt_o), 32'(((k % 7) == 3) ? 1 : 0));
            check_eq("t1_total", 32'(boost_total_o), 32'((k + 4) / 7));
        end
        // Asynchronous reset in the middle of a boost.
        pulse_reset();

        // Granted cycle in between two short stall runs: no boost.
        policy_i = 2'b10;
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_req(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        check_eq("t2_cnt3", 32'(stall_cnt_o), 32'd3);
        set_req(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check_eq("t2_gnt_clr", 32'(stall_cnt_o), 32'd0);
        set_req(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        check_eq("t2_noboost", 32'(boost_o), 32'd0);
        check_eq("t2_total",   32'(boost_total_o), 32'd0);
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Boost of length 8 cut short by HWPE dropping its request.
        boost_len_i = 4'd8;
        set_req(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) tick();
        check_eq("t3_entry", 32'(boost_o), 32'd1);
        tick();
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("t3_exit_boost", 32'(boost_o),     32'd0);
        check_eq("t3_exit_prio",  32'(hwpe_prio_o), 32'd0);

        // Round-robin with period 2, then idle cycles.
        policy_i    = 2'b11;
        rr_period_i = 8'd2;
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k < 6) set_req(1'b1, 1'b0, 1'b1, 1'b0);
            else       set_req(1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            check_eq("t4_rr", 32'(hwpe_prio_o), 32'(rr_exp[k]));
        end

        // Fixed HWPE priority, switch to starvation policy, enable pulse.
        policy_i = 2'b01;
        set_req(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (2) tick();
        check_eq("t5_hwpe", 32'(hwpe_prio_o), 32'd1);
        policy_i    = 2'b10;
        max_stall_i = 8'd6;
        tick();
        check_eq("t5_switch", 32'(hwpe_prio_o), 32'd0);
        repeat (2) tick();
        check_eq("t5_cnt", 32'(stall_cnt_o), 32'd2);
        en_i = 1'b0;
        tick();
        check_eq("t5_en_cnt", 32'(stall_cnt_o), 32'd0);
        en_i = 1'b1;

        // Boosting disabled: stall counter saturates without wrapping.
        max_stall_i = 8'd0;
        repeat (300) tick();
        check_eq("t6_sat", 32'(stall_cnt_o), 32'd255);
        check_eq("t6_noboost", 32'(boost_o), 32'd0);
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Boost every other cycle until the event counter saturates.
        max_stall_i = 8'd1;
        boost_len_i = 4'd0;
        set_req(1'b0, 1'b0, 1'b1, 1'b0);
        prev_evt = 1'b0;
        repeat (40) begin
            tick();
            check_eq("t7_evt_gap", 32'(prev_evt & boost_evt_o), 32'd0);
            prev_evt = boost_evt_o;
        end
        check_eq("t7_total_sat", 32'(boost_total_o), 32'd15);

        // Randomized run.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) policy_i = 2'($urandom_range(0, 3));
            en_i    = ($urandom_range(0, 31) != 0);
            clear_i = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 31) == 0) begin
                max_stall_i = 8'($urandom_range(0, 6));
                boost_len_i = 4'($urandom_range(0, 5));
                rr_period_i = 8'($urandom_range(0, 4));
            end
            core_req_i = ($urandom_range(0, 1) == 1);
            core_gnt_i = core_req_i & ($urandom_range(0, 1) == 1);
            hwpe_req_i = ($urandom_range(0, 3) != 0);
            hwpe_gnt_i = hwpe_req_i & ($urandom_range(0, 3) == 0);
            tick();
        end
        clear_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
